// File: rtl/accum_seq_pkg.sv
// Shared types and widths for the accumulation sequencer slice.
package accum_seq_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    function automatic int unsigned acc_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

    localparam int unsigned ACC_WIDTH = acc_width(DEFAULT_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/accum_sequencer_accum.sv
// Accumulator: synchronous clear has priority over add; sum wraps modulo 2^WIDTH.
module accum_sequencer_accum
    import accum_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH
) (
    input  logic             Clk,
    input  logic             clear,
    input  logic             add,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + addend;
        end
    end

    always_ff @(posedge Clk) begin
        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/accum_sequencer.sv
// Sequences one accumulation job: clear, stream LENGTH addends, present the sum.
// Optional sticky carry-out flag on port ovf when ACCUM_SEQ_OVF_EN is defined.
module accum_sequencer
    import accum_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    length,
    output logic                    busy,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready
`ifdef ACCUM_SEQ_OVF_EN
    ,
    output logic                    ovf
`endif
);

    localparam int unsigned AW = acc_width(DATA_WIDTH);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 acc_clear, acc_add;
    logic [AW-1:0]        acc_sum;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = length;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (remaining_q == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (acc_add) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        in_ready     = (state_q == ACCUM);
        result_valid = (state_q == DONE);
        acc_clear    = Rst || (state_q == CLEAR);
        acc_add      = (state_q == ACCUM) && in_valid && in_ready;
    end

    accum_sequencer_accum #(
        .WIDTH (AW)
    ) u_accum (
        .Clk    (Clk),
        .clear  (acc_clear),
        .add    (acc_add),
        .addend (in_data),
        .sum    (acc_sum)
    );

    // Accumulator only moves in CLEAR/ACCUM, so the sum is stable through DONE and IDLE.
    assign result = acc_sum;

`ifdef ACCUM_SEQ_OVF_EN
    logic          ovf_q, ovf_d;
    logic [AW:0]   wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc_sum} + {1'b0, in_data};
        ovf_d    = ovf_q;
        if (acc_clear) begin
            ovf_d = 1'b0;
        end else if (acc_add && wide_sum[AW]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Randomized self-checking bench for accum_sequencer (DATA_WIDTH=8) against a queue-based sum model.
module tb_accum_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = 2 * DW;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [LW-1:0] length;
    logic          busy;
    logic [AW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] result;
    logic          result_valid;
    logic          result_ready;
`ifdef ACCUM_SEQ_OVF_EN
    logic          ovf;
`endif

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [AW-1:0] fixed_q[$];

    accum_sequencer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .start        (start),
        .length       (length),
        .busy         (busy),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef ACCUM_SEQ_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one job; inputs change on negedge, outputs sampled 1ns later (well away from posedge).
    task automatic do_job(input int unsigned len, input int unsigned stall_pct,
                          input int unsigned bp, input bit poke);
        logic [AW-1:0] accepted[$];
        logic [AW-1:0] exp_sum;
        logic [AW:0]   step;
        bit            exp_ovf;
        int unsigned   t;
        bit            got;

        @(negedge Clk);
        start = 1'b1; length = LW'(len); in_valid = 1'b0; result_ready = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        t = 0; got = 0;
        while (!got && t < 600) begin
            @(negedge Clk);
            t++;
            start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            length   = LW'($urandom);
            in_valid = ($urandom_range(0, 99) >= stall_pct);
            in_data  = (fixed_q.size() != 0) ? fixed_q[0] : AW'($urandom);
            #1;
            if (result_valid) begin
                got = 1;
            end else begin
                check("busy", busy, 1);
                check("in_ready", in_ready, (t >= 2) && (accepted.size() < len));
                if (in_valid && in_ready) begin
                    accepted.push_back(in_data);
                    if (fixed_q.size() != 0) void'(fixed_q.pop_front());
                end
            end
        end
        check("done_seen", got, 1);

        exp_sum = '0; exp_ovf = 0;
        foreach (accepted[i]) begin
            step    = {1'b0, exp_sum} + {1'b0, accepted[i]};
            exp_ovf = exp_ovf | step[AW];
            exp_sum = exp_sum + accepted[i];
        end
        check("handshakes", accepted.size(), len);
        check("result", result, exp_sum);
        check("done_in_ready", in_ready, 0);
        if (stall_pct == 0) check("latency", t, len + 2);
`ifdef ACCUM_SEQ_OVF_EN
        check("ovf", ovf, exp_ovf);
`endif

        for (int unsigned i = 0; i < bp; i++) begin
            @(negedge Clk);
            result_ready = 1'b0; in_valid = 1'b1; in_data = AW'($urandom);
            #1;
            check("bp_valid", result_valid, 1);
            check("bp_result", result, exp_sum);
            check("bp_in_ready", in_ready, 0);
        end

        // Start presented in the DONE exit cycle must be ignored.
        @(negedge Clk);
        result_ready = 1'b1; start = 1'b1; length = LW'(3);
        @(negedge Clk);
        result_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        #1;
        check("idle_after_done", busy, 0);
        check("idle_valid", result_valid, 0);
        check("idle_result_hold", result, exp_sum);
        @(negedge Clk);
        #1;
        check("no_restart", busy, 0);
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; length = '0; in_data = '0; in_valid = 1'b0; result_ready = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
`ifdef ACCUM_SEQ_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge Clk);
        Rst = 1'b0;

        fixed_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_job(4, 0, 0, 0);
        fixed_q = '{16'd5, 16'd7, 16'd9};
        do_job(3, 60, 3, 0);
        fixed_q.delete();
        do_job(0, 0, 1, 0);
        fixed_q = '{16'h10, 16'h20};
        do_job(2, 30, 0, 1);
        fixed_q = '{16'd3};
        do_job(1, 0, 0, 0);
        fixed_q = '{16'hFFFF, 16'h0002};
        do_job(2, 0, 0, 0);
        fixed_q = '{16'd1};
        do_job(1, 0, 0, 0);

        // Reset after two handshakes of a five-element job.
        @(negedge Clk);
        start = 1'b1; length = LW'(5); in_valid = 1'b1; in_data = 16'h0042;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_result", result, 0);
`ifdef ACCUM_SEQ_OVF_EN
        check("mid_rst_ovf", ovf, 0);
`endif
        repeat (3) begin
            @(negedge Clk);
            #1;
            check("post_rst_in_ready", in_ready, 0);
            check("post_rst_busy", busy, 0);
        end
        fixed_q = '{16'd9};
        do_job(1, 0, 0, 0);

        for (int j = 0; j < 20; j++) begin
            fixed_q.delete();
            do_job($urandom_range(0, 12), $urandom_range(0, 50),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Sequences one accumulation job on the team's 2*DATA_WIDTH accumulator. A job is accepted on a start pulse with an element count. The block clears the accumulator, then streams exactly that many addends in over a valid/ready handshake. It then presents the sum on a result valid/ready port. It sits between an operand producer (e.g. multiplier/DMA stage) and the consumer of reduced results.

Parameters:
DATA_WIDTH, 32, operand half-width; addend, accumulator and result are 2*DATA_WIDTH bits
LEN_WIDTH, 16, width of the job element count

Ports:
Clk  input  1  clock; all state changes on rising edge
Rst  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
length  input  LEN_WIDTH  element count, sampled with start; 0 is legal
busy  output  1  high whenever state != IDLE
in_data  input  2*DATA_WIDTH  addend
in_valid  input  1  producer has an addend
in_ready  output  1  block accepts an addend this cycle
result  output  2*DATA_WIDTH  accumulated sum
result_valid  output  1  result is valid
result_ready  input  1  consumer accepts result
ovf  output  1  sticky carry-out flag (only with ACCUM_SEQ_OVF_EN)

Behaviour:
- Reset: state=IDLE; busy=0, in_ready=0, result_valid=0, result=0, ovf=0, remaining count=0. Rst is also forwarded to the accumulator's clear. Reset mid-job aborts the job with no result and no partial handshake afterwards.
- States: IDLE, CLEAR, ACCUM, DONE.
- IDLE: start=1 -> latch length into remaining counter, go to CLEAR. While busy, start is ignored and length is not re-sampled.
- CLEAR (exactly 1 cycle): assert accumulator clear. If remaining==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready: assert accumulator add with addend=in_data, and decrement remaining.
  - Handshake while remaining==1 -> DONE.
  - in_valid low: stall, no add, no count change.
  - Throughput 1 addend/cycle.
- DONE:
  - result_valid=1; result = accumulator sum, stable for the whole DONE state.
  - result_ready=1 -> IDLE. A start in that same cycle is not accepted; it must be presented in IDLE.
  - result_valid held indefinitely under backpressure.
- result keeps its last value in IDLE and changes only after the next CLEAR.
- Latency: with in_valid held high, result_valid asserts L+2 cycles after the cycle start is sampled (L=length). For L=0 this is 2 cycles.
- Arithmetic: unsigned, modulo 2^(2*DATA_WIDTH); carry-out is discarded.
- in_ready is low in IDLE, CLEAR and DONE. Data offered then is not consumed.

Optional Feature:
Macro ACCUM_SEQ_OVF_EN.
- Defined:
  - Port ovf exists.
  - On each ACCUM handshake, the block computes sum+in_data with 1 extra bit. Carry-out=1 sets ovf.
  - ovf is cleared in CLEAR and by Rst.
  - ovf is valid alongside result_valid and holds until the next CLEAR.
- Undefined: port ovf and its logic are absent; wrap-around is silent.

Decomposition:
- Package accum_seq_pkg holds:
  - the state encoding typedef (IDLE/CLEAR/ACCUM/DONE, 2 bits);
  - a localparam for accumulator width (2*DATA_WIDTH) as a function of DATA_WIDTH.
- One sub-module: the team's existing accumulator block. It is instantiated unchanged, with its clear driven by (Rst || state==CLEAR) and its add driven by (state==ACCUM && in_valid && in_ready).
- The FSM, counter and overflow logic live in accum_sequencer.

Test Plan:
- Basic job: length=4, in_valid always 1, in_data=1,2,3,4 -> exactly 4 handshakes; result_valid at start+6 cycles with result=10; result_ready=1 -> IDLE next cycle, busy=0.
- Stalls/backpressure: length=3, data 5,7,9 with in_valid low for 2 cycles between each, and result_ready held low 3 cycles -> result=21; result_valid and result stable for all 3 stalled cycles; no extra adds.
- Zero length: start with length=0 -> CLEAR then DONE; result=0 and result_valid at start+2 cycles; in_ready never asserted.
- Back-to-back jobs and ignored start: job A (length=2, data 0x10,0x20), with start pulsed again mid-ACCUM -> result 0x30 and no second job begins. Then job B (length=1, data 3) -> result 3, proving clear between jobs.
- Wrap/overflow (DATA_WIDTH=8): length=2, data 0xFFFF,0x0002 -> result=0x0001. With ACCUM_SEQ_OVF_EN: ovf=1. A following job with data 1 gives ovf=0.
- Reset mid-job: length=5, Rst after 2 handshakes -> next cycle IDLE with all outputs at reset values. A new job of length=1 with data 9 then gives result=9.
